versal_pl_axil_regs: RTL and testbench

AXI4-Lite responder in Versal PL: target of CPM/PS-initiated register accesses routed through the NoC/PS master port in the PS block design. Holds the board control/status register bank for the OBC module: version, scratch, control outputs, sampled status inputs, a single interrupt with W1C status, and an optional cycle counter. One outstanding write and one outstanding read; the write and read channels are independent.

---
 rtl/versal_pl_axil_regs.sv | 243 ++++++++++++++++++++++++
 tb/tb_versal_pl_axil_regs.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/versal_pl_axil_regs.sv
// versal_pl_axil_regs: AXI4-Lite register bank for the OBC module (version, scratch,
// control outputs, status inputs, one W1C interrupt). One outstanding write and one
// outstanding read, with independent channels.
// Optional feature: define VERSAL_PL_AXIL_CYCLE_COUNT_EN to map a free-running
// 32-bit cycle counter at offset 0x008 (otherwise 0x008 is unmapped).
module versal_pl_axil_regs #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter logic [31:0] VERSION    = 32'h2025_0100
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [ADDR_WIDTH-1:0] S_AXI_AWADDR,
  input  logic                  S_AXI_AWVALID,
  output logic                  S_AXI_AWREADY,
  input  logic [31:0]           S_AXI_WDATA,
  input  logic [3:0]            S_AXI_WSTRB,
  input  logic                  S_AXI_WVALID,
  output logic                  S_AXI_WREADY,
  output logic [1:0]            S_AXI_BRESP,
  output logic                  S_AXI_BVALID,
  input  logic                  S_AXI_BREADY,
  input  logic [ADDR_WIDTH-1:0] S_AXI_ARADDR,
  input  logic                  S_AXI_ARVALID,
  output logic                  S_AXI_ARREADY,
  output logic [31:0]           S_AXI_RDATA,
  output logic [1:0]            S_AXI_RRESP,
  output logic                  S_AXI_RVALID,
  input  logic                  S_AXI_RREADY,
  output logic [7:0]            CTRL,
  input  logic [7:0]            STATUS,
  input  logic                  EVENT,
  output logic                  IRQ
);

  localparam int unsigned WW = ADDR_WIDTH - 2;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [WW-1:0] OFF_VERSION  = WW'(0);
  localparam logic [WW-1:0] OFF_SCRATCH  = WW'(1);
  localparam logic [WW-1:0] OFF_CYCLE    = WW'(2);
  localparam logic [WW-1:0] OFF_CONTROL  = WW'(3);
  localparam logic [WW-1:0] OFF_STATUS   = WW'(4);
  localparam logic [WW-1:0] OFF_IRQ_STAT = WW'(5);
  localparam logic [WW-1:0] OFF_IRQ_EN   = WW'(6);

  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  function automatic logic is_mapped(input logic [WW-1:0] word);
    case (word)
      OFF_VERSION, OFF_SCRATCH, OFF_CONTROL, OFF_STATUS, OFF_IRQ_STAT, OFF_IRQ_EN:
        is_mapped = 1'b1;
`ifdef VERSAL_PL_AXIL_CYCLE_COUNT_EN
      OFF_CYCLE: is_mapped = 1'b1;
`endif
      default: is_mapped = 1'b0;
    endcase
  endfunction

  logic          ready_en;
  w_state_t      w_state_q, w_state_d;
  r_state_t      r_state_q, r_state_d;
  logic          aw_held, w_held;
  logic [WW-1:0] aw_word_q;
  logic [31:0]   w_data_q;
  logic [3:0]    w_strb_q;
  logic          aw_hs, w_hs, ar_hs, wr_commit;
  logic [WW-1:0] wr_word, ar_word;
  logic [31:0]   wr_data;
  logic [3:0]    wr_strb;
  logic [1:0]    bresp_q, rresp_q;
  logic [31:0]   rdata_q, rd_mux;
  logic [31:0]   scratch_q;
  logic [7:0]    ctrl_q;
  logic          irq_stat_q, irq_en_q, irq_q, event_q, event_rise, irq_clr;
  logic          unused_addr_lsbs;
`ifdef VERSAL_PL_AXIL_CYCLE_COUNT_EN
  logic [31:0]   cycle_cnt;
`endif

  // Byte-lane bits of the addresses carry no meaning for 32-bit registers.
  assign unused_addr_lsbs = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  assign S_AXI_AWREADY = ready_en & (w_state_q == W_IDLE) & ~aw_held;
  assign S_AXI_WREADY  = ready_en & (w_state_q == W_IDLE) & ~w_held;
  assign S_AXI_BVALID  = (w_state_q == W_RESP);
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = ready_en & (r_state_q == R_IDLE);
  assign S_AXI_RVALID  = (r_state_q == R_DATA);
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;
  assign CTRL          = ctrl_q;
  assign IRQ           = irq_q;

  assign aw_hs = S_AXI_AWVALID & S_AXI_AWREADY;
  assign w_hs  = S_AXI_WVALID & S_AXI_WREADY;
  assign ar_hs = S_AXI_ARVALID & S_AXI_ARREADY;

  // A beat captured earlier takes precedence; otherwise use the beat arriving now.
  assign wr_word = aw_held ? aw_word_q : S_AXI_AWADDR[ADDR_WIDTH-1:2];
  assign wr_data = w_held ? w_data_q : S_AXI_WDATA;
  assign wr_strb = w_held ? w_strb_q : S_AXI_WSTRB;
  assign ar_word = S_AXI_ARADDR[ADDR_WIDTH-1:2];

  assign event_rise = EVENT & ~event_q;
  assign irq_clr    = wr_commit & (wr_word == OFF_IRQ_STAT) & wr_strb[0] & wr_data[0];

  // Ready outputs stay low in reset and rise on the first clock after it.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) ready_en <= 1'b0;
    else     ready_en <= 1'b1;
  end

  // Write FSM next state: commit once both address and data are available.
  always_comb begin
    w_state_d = w_state_q;
    wr_commit = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        if ((aw_held | aw_hs) & (w_held | w_hs)) begin
          wr_commit = 1'b1;
          w_state_d = W_RESP;
        end
      end
      W_RESP: if (S_AXI_BREADY) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  // Write channel state, beat holding registers and write response.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      w_state_q <= W_IDLE;
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      aw_word_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bresp_q   <= RESP_OKAY;
    end else begin
      w_state_q <= w_state_d;
      if (wr_commit) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
        bresp_q <= is_mapped(wr_word) ? RESP_OKAY : RESP_SLVERR;
      end else begin
        if (aw_hs) begin
          aw_held   <= 1'b1;
          aw_word_q <= S_AXI_AWADDR[ADDR_WIDTH-1:2];
        end
        if (w_hs) begin
          w_held   <= 1'b1;
          w_data_q <= S_AXI_WDATA;
          w_strb_q <= S_AXI_WSTRB;
        end
      end
    end
  end

  // Read data mux over the current register values.
  always_comb begin
    rd_mux = '0;
    case (ar_word)
      OFF_VERSION:  rd_mux = VERSION;
      OFF_SCRATCH:  rd_mux = scratch_q;
`ifdef VERSAL_PL_AXIL_CYCLE_COUNT_EN
      OFF_CYCLE:    rd_mux = cycle_cnt;
`endif
      OFF_CONTROL:  rd_mux = {24'h0, ctrl_q};
      OFF_STATUS:   rd_mux = {24'h0, STATUS};
      OFF_IRQ_STAT: rd_mux = {31'h0, irq_stat_q};
      OFF_IRQ_EN:   rd_mux = {31'h0, irq_en_q};
      default:      rd_mux = '0;
    endcase
  end

  // Read FSM next state.
  always_comb begin
    r_state_d = r_state_q;
    case (r_state_q)
      R_IDLE:  if (ar_hs) r_state_d = R_DATA;
      R_DATA:  if (S_AXI_RREADY) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  // Read state and registered read data, held stable until accepted.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state_q <= R_IDLE;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      r_state_q <= r_state_d;
      if (ar_hs) begin
        rdata_q <= rd_mux;
        rresp_q <= is_mapped(ar_word) ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

  // Writable registers; SCRATCH honours every byte lane, the rest only lane 0.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      scratch_q <= '0;
      ctrl_q    <= '0;
      irq_en_q  <= 1'b0;
    end else if (wr_commit) begin
      if (wr_word == OFF_SCRATCH) begin
        for (int unsigned i = 0; i < 4; i++) begin
          if (wr_strb[i]) scratch_q[8*i +: 8] <= wr_data[8*i +: 8];
        end
      end
      if ((wr_word == OFF_CONTROL) && wr_strb[0]) ctrl_q <= wr_data[7:0];
      if ((wr_word == OFF_IRQ_EN) && wr_strb[0]) irq_en_q <= wr_data[0];
    end
  end

  // Interrupt status: EVENT rising edge sets and beats a simultaneous W1C.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      event_q    <= 1'b0;
      irq_stat_q <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      event_q <= EVENT;
      if (event_rise)   irq_stat_q <= 1'b1;
      else if (irq_clr) irq_stat_q <= 1'b0;
      irq_q <= irq_stat_q & irq_en_q;
    end
  end

`ifdef VERSAL_PL_AXIL_CYCLE_COUNT_EN
  // Free-running cycle counter, wraps naturally.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) cycle_cnt <= '0;
    else     cycle_cnt <= cycle_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_versal_pl_axil_regs.sv
// Directed self-checking bench for versal_pl_axil_regs.
module tb_versal_pl_axil_regs;

  localparam logic [31:0] VER    = 32'h2025_0100;
  localparam logic [1:0]  OKAY   = 2'b00;
  localparam logic [1:0]  SLVERR = 2'b10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] awaddr = '0;
  logic        awvalid = 1'b0, awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wvalid = 1'b0, wready;
  logic [1:0]  bresp;
  logic        bvalid, bready = 1'b0;
  logic [11:0] araddr = '0;
  logic        arvalid = 1'b0, arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid, rready = 1'b0;
  logic [7:0]  ctrl;
  logic [7:0]  status = 8'h3C;
  logic        event_in = 1'b0;
  logic        irq;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  versal_pl_axil_regs #(.ADDR_WIDTH(12), .VERSION(VER)) dut (
    .CLK(clk), .RST(rst),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .CTRL(ctrl), .STATUS(status), .EVENT(event_in), .IRQ(irq)
  );

  // Write with AW asserted first and W asserted w_delay cycles later.
  task automatic axi_write(input logic [11:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int unsigned w_delay, output logic [1:0] resp, output bit tmo);
    int unsigned c;
    bit aw_p, w_p, aw_f, w_f;
    tmo = 1'b0; resp = 2'bxx; c = 0; aw_p = 1'b1; w_p = 1'b1;
    awaddr = addr; wdata = data; wstrb = strb; awvalid = 1'b1;
    while ((aw_p || w_p) && c < 32) begin
      if (w_p && c >= w_delay) wvalid = 1'b1;
      aw_f = awvalid && awready;
      w_f  = wvalid && wready;
      @(posedge clk); #1; c++;
      if (aw_f) begin awvalid = 1'b0; aw_p = 1'b0; end
      if (w_f)  begin wvalid = 1'b0;  w_p = 1'b0;  end
    end
    if (aw_p || w_p) begin tmo = 1'b1; awvalid = 1'b0; wvalid = 1'b0; return; end
    bready = 1'b1; c = 0;
    while (!bvalid && c < 32) begin @(posedge clk); #1; c++; end
    if (!bvalid) begin tmo = 1'b1; bready = 1'b0; return; end
    resp = bresp;
    @(posedge clk); #1;
    bready = 1'b0;
  endtask

  // Read; lat counts edges from the AR handshake edge until RVALID is seen.
  task automatic axi_read(input logic [11:0] addr, output logic [31:0] data, output logic [1:0] resp,
                          output int unsigned lat, output bit tmo);
    int unsigned c;
    bit f;
    tmo = 1'b0; data = 'x; resp = 'x; lat = 0; c = 0; f = 1'b0;
    araddr = addr; arvalid = 1'b1;
    while (!f && c < 32) begin f = arready; @(posedge clk); #1; c++; end
    arvalid = 1'b0;
    if (!f) begin tmo = 1'b1; return; end
    c = 1;
    while (!rvalid && c < 32) begin @(posedge clk); #1; c++; end
    lat = c;
    if (!rvalid) begin tmo = 1'b1; return; end
    data = rdata; resp = rresp;
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d; logic [1:0] r; int unsigned lat; bit t;
    event_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({awready, wready, arready, bvalid, rvalid, irq} !== 6'b0) begin
      failures++; $display("FAIL reset_handshake: got %b required 000000", {awready, wready, arready, bvalid, rvalid, irq});
    end
    checks++;
    if ({ctrl, bresp, rresp, rdata} !== 44'h0) begin
      failures++; $display("FAIL reset_outputs: ctrl=%h bresp=%b rresp=%b rdata=%h required all 0", ctrl, bresp, rresp, rdata);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (arready !== 1'b0) begin failures++; $display("FAIL ready_before_edge: got %b required 0", arready); end
    @(posedge clk); #1;
    checks++;
    if ({awready, wready, arready} !== 3'b111) begin
      failures++; $display("FAIL ready_after_edge: got %b required 111", {awready, wready, arready});
    end
    axi_read(12'h014, d, r, lat, t);
    checks++;
    if (t || d !== 32'h1) begin failures++; $display("FAIL event_through_reset: got %h tmo=%0d required 00000001", d, t); end
    axi_write(12'h014, 32'h1, 4'h1, 0, r, t);
    event_in = 1'b0;
    axi_read(12'h014, d, r, lat, t);
    checks++;
    if (t || d !== 32'h0) begin failures++; $display("FAIL w1c_after_reset: got %h required 00000000", d); end
  endtask

  task automatic test_read_basic();
    logic [31:0] d; logic [1:0] r; int unsigned lat; bit t;
    axi_read(12'h000, d, r, lat, t);
    checks++;
    if (t || d !== VER || r !== OKAY) begin
      failures++; $display("FAIL read_version: got %h/%b required %h/%b", d, r, VER, OKAY);
    end
    checks++;
    if (lat !== 1) begin failures++; $display("FAIL read_latency: got %0d required 1", lat); end
    axi_read(12'h004, d, r, lat, t);
    checks++;
    if (t || d !== 32'h0 || r !== OKAY) begin failures++; $display("FAIL scratch_reset: got %h/%b required 0/00", d, r); end
    axi_read(12'h010, d, r, lat, t);
    checks++;
    if (t || d !== 32'h3C || r !== OKAY) begin failures++; $display("FAIL status_read: got %h/%b required 0000003c/00", d, r); end
  endtask

  task automatic test_wstrb();
    logic [31:0] d; logic [1:0] r; int unsigned lat; bit t;
    axi_write(12'h004, 32'hDEAD_BEEF, 4'b0101, 3, r, t);
    checks++;
    if (t || r !== OKAY) begin failures++; $display("FAIL wstrb_bresp: got %b tmo=%0d required 00", r, t); end
    axi_read(12'h004, d, r, lat, t);
    checks++;
    if (t || d !== 32'h00AD_00EF) begin failures++; $display("FAIL wstrb_readback: got %h required 00ad00ef", d); end
  endtask

  task automatic test_control_decode();
    logic [31:0] d; logic [1:0] r; int unsigned lat; bit t;
    axi_write(12'h00C, 32'h0000_01A5, 4'hF, 0, r, t);
    checks++;
    if (t || r !== OKAY || ctrl !== 8'hA5) begin
      failures++; $display("FAIL ctrl_write: ctrl=%h bresp=%b required a5/00", ctrl, r);
    end
    axi_read(12'h00C, d, r, lat, t);
    checks++;
    if (t || d !== 32'h0000_00A5) begin failures++; $display("FAIL ctrl_readback: got %h required 000000a5", d); end
    axi_write(12'h00C, 32'h0000_00FF, 4'hE, 0, r, t);
    checks++;
    if (t || r !== OKAY || ctrl !== 8'hA5) begin
      failures++; $display("FAIL ctrl_lane0_off: ctrl=%h bresp=%b required a5/00", ctrl, r);
    end
    axi_write(12'h100, 32'h0000_1234, 4'hF, 0, r, t);
    checks++;
    if (t || r !== SLVERR) begin failures++; $display("FAIL unmapped_bresp: got %b required 10", r); end
    axi_read(12'h100, d, r, lat, t);
    checks++;
    if (t || d !== 32'h0 || r !== SLVERR) begin failures++; $display("FAIL unmapped_read: got %h/%b required 0/10", d, r); end
  endtask

  task automatic test_irq();
    logic [31:0] d; logic [1:0] r; int unsigned lat; bit t;
    axi_write(12'h018, 32'h1, 4'h1, 0, r, t);
    event_in = 1'b1;
    @(posedge clk); #1;
    event_in = 1'b0;
    checks++;
    if (irq !== 1'b0) begin failures++; $display("FAIL irq_lag: got %b required 0", irq); end
    @(posedge clk); #1;
    checks++;
    if (irq !== 1'b1) begin failures++; $display("FAIL irq_rise: got %b required 1", irq); end
    axi_read(12'h014, d, r, lat, t);
    checks++;
    if (t || d !== 32'h1) begin failures++; $display("FAIL irq_stat_set: got %h required 00000001", d); end
    // W1C committing on the same edge as a new EVENT rise
    awaddr = 12'h014; wdata = 32'h1; wstrb = 4'h1; awvalid = 1'b1; wvalid = 1'b1; event_in = 1'b1;
    checks++;
    if ({awready, wready} !== 2'b11) begin failures++; $display("FAIL w1c_ready: got %b required 11", {awready, wready}); end
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0; event_in = 1'b0;
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    axi_read(12'h014, d, r, lat, t);
    checks++;
    if (t || d !== 32'h1 || irq !== 1'b1) begin
      failures++; $display("FAIL set_beats_w1c: stat=%h irq=%b required 00000001/1", d, irq);
    end
    // plain W1C: IRQ drops one cycle after the status clears
    awaddr = 12'h014; wdata = 32'h1; wstrb = 4'h1; awvalid = 1'b1; wvalid = 1'b1;
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    checks++;
    if (irq !== 1'b1 || bvalid !== 1'b1) begin
      failures++; $display("FAIL w1c_irq_hold: irq=%b bvalid=%b required 1/1", irq, bvalid);
    end
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    checks++;
    if (irq !== 1'b0) begin failures++; $display("FAIL w1c_irq_fall: got %b required 0", irq); end
  endtask

  task automatic test_backpressure();
    logic [31:0] d; logic [1:0] r; int unsigned lat; bit t;
    int bad;
    // simultaneous write and read of SCRATCH: read sees the old value
    awaddr = 12'h004; wdata = 32'h1122_3344; wstrb = 4'hF; araddr = 12'h004;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (bvalid !== 1'b1 || rvalid !== 1'b1 || bresp !== OKAY || rdata !== 32'h00AD_00EF ||
          awready !== 1'b0 || wready !== 1'b0 || arready !== 1'b0) bad++;
      @(posedge clk); #1;
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL stall_stable: %0d bad cycles required 0", bad); end
    bready = 1'b1; rready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0; rready = 1'b0;
    checks++;
    if ({bvalid, rvalid, awready, arready} !== 4'b0011) begin
      failures++; $display("FAIL stall_release: got %b required 0011", {bvalid, rvalid, awready, arready});
    end
    axi_read(12'h004, d, r, lat, t);
    checks++;
    if (t || d !== 32'h1122_3344) begin failures++; $display("FAIL post_stall_scratch: got %h required 11223344", d); end
    // reset in the middle of pending responses
    awaddr = 12'h018; wdata = 32'h1; wstrb = 4'h1; araddr = 12'h000;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if ({bvalid, rvalid} !== 2'b00) begin failures++; $display("FAIL reset_drop: got %b required 00", {bvalid, rvalid}); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    axi_read(12'h000, d, r, lat, t);
    checks++;
    if (t || d !== VER || r !== OKAY) begin failures++; $display("FAIL read_after_reset: got %h/%b required %h/00", d, r, VER); end
    axi_read(12'h004, d, r, lat, t);
    checks++;
    if (t || d !== 32'h0) begin failures++; $display("FAIL scratch_cleared: got %h required 00000000", d); end
  endtask

  task automatic test_back_to_back();
    araddr = 12'h000; arvalid = 1'b1; rready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({rvalid, arready} !== 2'b10) begin failures++; $display("FAIL b2b_first: got %b required 10", {rvalid, arready}); end
    @(posedge clk); #1;
    checks++;
    if ({rvalid, arready} !== 2'b01) begin failures++; $display("FAIL b2b_gap: got %b required 01", {rvalid, arready}); end
    @(posedge clk); #1;
    arvalid = 1'b0;
    checks++;
    if (rvalid !== 1'b1 || rdata !== VER) begin failures++; $display("FAIL b2b_second: rvalid=%b rdata=%h required 1/%h", rvalid, rdata, VER); end
    @(posedge clk); #1;
    rready = 1'b0;
  endtask

  task automatic test_cycle_count();
    logic [31:0] d, d2; logic [1:0] r; int unsigned lat; bit t;
`ifdef VERSAL_PL_AXIL_CYCLE_COUNT_EN
    araddr = 12'h008; arvalid = 1'b1; rready = 1'b1;
    @(posedge clk); #1;
    arvalid = 1'b0;
    d = rdata;
    repeat (4) @(posedge clk);
    #1;
    arvalid = 1'b1;
    @(posedge clk); #1;
    arvalid = 1'b0;
    d2 = rdata;
    checks++;
    if (rvalid !== 1'b1 || rresp !== OKAY || (d2 - d) !== 32'd5) begin
      failures++; $display("FAIL cycle_delta: got %0d required 5", d2 - d);
    end
    @(posedge clk); #1;
    force dut.cycle_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.cycle_cnt;
    @(posedge clk); #1;
    @(posedge clk); #1;
    arvalid = 1'b1;
    @(posedge clk); #1;
    arvalid = 1'b0;
    checks++;
    if (rvalid !== 1'b1 || rdata !== 32'h0) begin failures++; $display("FAIL cycle_wrap: got %h required 00000000", rdata); end
    @(posedge clk); #1;
    rready = 1'b0;
    axi_write(12'h008, 32'h5555_5555, 4'hF, 0, r, t);
    checks++;
    if (t || r !== OKAY) begin failures++; $display("FAIL cycle_write_resp: got %b required 00", r); end
`else
    axi_read(12'h008, d, r, lat, t);
    checks++;
    if (t || d !== 32'h0 || r !== SLVERR) begin failures++; $display("FAIL cycle_unmapped_read: got %h/%b required 0/10", d, r); end
    axi_write(12'h008, 32'h5555_5555, 4'hF, 0, r, t);
    d2 = 32'h0;
    checks++;
    if (t || r !== SLVERR) begin failures++; $display("FAIL cycle_unmapped_write: got %b required 10 (%h)", r, d2); end
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_read_basic();
    test_wstrb();
    test_control_decode();
    test_irq();
    test_backpressure();
    test_back_to_back();
    test_cycle_count();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
